instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter QDEPTH, default 2, SHALL set the fetch queue depth in entries; legal values are powers of two, minimum 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port PC_IF, input, 32 bits: the current fetch address from the program counter.
REQ-005 Port j_br, input, 1 bit: jump/branch taken, which flushes the wrong path; the program counter loads bta on the next edge.
REQ-006 Port stall, output, 1 bit: high holds the program counter; low lets it advance by 4.
REQ-007 Port imem_req, output, 1 bit: instruction memory request valid.
REQ-008 Port imem_addr, output, 32 bits: the request address.
REQ-009 Port imem_gnt, input, 1 bit: the memory accepts the request this cycle.
REQ-010 Port imem_rvalid, input, 1 bit: the response word is valid this cycle.
REQ-011 Port imem_rdata, input, 32 bits: the response instruction word.
REQ-012 Port valid_ID, output, 1 bit: the queue head is valid for decode.
REQ-013 Port instr_ID, output, 32 bits: the queue-head instruction.
REQ-014 Port PC_ID, output, 32 bits: the queue-head PC.
REQ-015 Port id_ready, input, 1 bit: decode consumes the head this cycle when valid_ID is also high.

Function
REQ-016 imem_addr SHALL equal PC_IF combinationally.
REQ-017 The memory protocol SHALL be: one response per granted request, in order, at least 1 cycle after the grant; at most one request outstanding.
REQ-018 The FSM SHALL have three states: IDLE (none outstanding), WAIT (one outstanding, to keep), DROP (one outstanding, to discard).
REQ-019 Definitions: push = state==WAIT && imem_rvalid && !j_br; pop = valid_ID && id_ready && !j_br.
REQ-020 imem_req SHALL be high iff all of the following hold: !reset; !j_br; (state==IDLE or (state==WAIT and imem_rvalid)); (count + push − pop) < QDEPTH.
REQ-021 stall SHALL be high iff reset or !(imem_req && imem_gnt); the PC advances only on an accepted request.
REQ-022 On an accepted request, the PC_IF value SHALL be captured as the outstanding PC.
REQ-023 On push, the queue SHALL append {outstanding PC, imem_rdata}.
REQ-024 Transitions:
- IDLE→WAIT on accept.
- WAIT→IDLE on rvalid without accept.
- WAIT stays WAIT on rvalid with accept.
- WAIT→DROP on j_br without rvalid.
- WAIT→IDLE on j_br with rvalid; that word is discarded.
- DROP→IDLE on rvalid; the word is discarded and no issue occurs that cycle.
- DROP stays DROP on j_br.
REQ-025 On j_br, the queue SHALL be cleared on the next edge; that cycle's pop and push SHALL be ignored.
REQ-026 When the queue is empty, valid_ID SHALL be 0, instr_ID SHALL be 32'h0000_0013 (NOP), and PC_ID SHALL be 0.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-028 With QDEPTH=2, zero-latency-plus-one memory, and id_ready held high, sustained throughput SHALL be one instruction every cycle after the first response.
REQ-029 Pointers SHALL wrap modulo QDEPTH; count SHALL be log2(QDEPTH)+1 bits wide and never exceed QDEPTH.

Reset
REQ-030 On a reset edge, the block SHALL set state=IDLE, count=0, pointers=0, and outstanding PC=0.
REQ-031 While reset is high, imem_req SHALL be 0 and stall SHALL be 1.
REQ-032 Reset asserted while WAIT or DROP SHALL abandon the outstanding response; the memory is reset in the same cycle.
REQ-033 After reset, valid_ID=0, instr_ID=32'h0000_0013, and PC_ID=0.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the FSM state encoding (IDLE, WAIT, DROP), the NOP constant 32'h0000_0013, and the QDEPTH default.
REQ-035 One sub-module, fetch_fifo, SHALL be used: a synchronous 64-bit-wide {PC, instr} FIFO with push, pop, clear, count, and head outputs.

Verification
REQ-036 Reset, then PC_IF=0, gnt=1, and rvalid one cycle after each grant with rdata=PC+0x100 -> first valid_ID appears 2 cycles after reset release with PC_ID=0 and instr_ID=0x100, then one instruction per cycle.
REQ-037 Hold id_ready=0 with the same memory -> exactly 2 entries are queued, imem_req drops, and stall stays high; releasing id_ready yields PC_ID 0,4,8 in order.
REQ-038 Raise j_br while WAIT, with the response arriving 2 cycles later (rdata=0xDEAD) -> 0xDEAD is never presented, the queue is empty the cycle after j_br, and the next fetch uses the new PC_IF=0x80.
REQ-039 Raise j_br in the same cycle as rvalid (rdata=0xBEEF) -> the word is discarded, state returns to IDLE, and imem_req is 0 that cycle.
REQ-040 Hold gnt=0 for 3 cycles -> stall stays high and PC_IF is held; gnt=1 then -> exactly one request, stall low for one cycle.
REQ-041 Assert reset in WAIT with valid_ID=1 -> after the edge: valid_ID=0, instr_ID=0x13, imem_req=0, stall=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, the NOP
// word presented on an empty queue, and the queue entry layout.
package fetch_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          QDEPTH_DEF = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {PC, instr} queue between fetch and decode. An empty queue
// presents PC 0 with a NOP so decode never sees stale data.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             din,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; occupancy tracking above decides what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head_valid = (count != '0);
    assign head       = head_valid ? mem[rd_ptr] : EMPTY_ENTRY;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one request at a time to instruction memory,
// queues returned words with their PC, and discards wrong-path responses.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_IF,
    input  logic        j_br,
    output logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_ID,
    output logic [31:0] instr_ID,
    output logic [31:0] PC_ID,
    input  logic        id_ready
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QDEPTH_W = QDEPTH[CW:0];

    logic [1:0]    state;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;
    logic [CW:0]   occ_next;
    logic          push;
    logic          pop;
    logic          accept;
    logic          head_valid;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign imem_addr = PC_IF;

    assign push = (state == WAIT) && imem_rvalid && !j_br;
    assign pop  = valid_ID && id_ready && !j_br;

    // Occupancy after this cycle's push/pop must leave room for the word
    // that a new request will eventually return.
    assign occ_next = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

    assign imem_req = !reset && !j_br
                      && ((state == IDLE) || ((state == WAIT) && imem_rvalid))
                      && (occ_next < QDEPTH_W);
    assign accept   = imem_req && imem_gnt;
    assign stall    = reset || !accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            out_pc <= '0;
        end else begin
            if (accept) out_pc <= PC_IF;
            case (state)
                IDLE: if (accept) state <= WAIT;
                WAIT: begin
                    if (j_br)             state <= imem_rvalid ? IDLE : DROP;
                    else if (imem_rvalid) state <= accept ? WAIT : IDLE;
                end
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign push_entry = '{pc: out_pc, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .clear      (j_br),
        .din        (push_entry),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign valid_ID = head_valid;
    assign instr_ID = head.instr;
    assign PC_ID    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written branch/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_instr_fetch;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_IF;
    logic        j_br;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_ID;
    logic [31:0] instr_ID;
    logic [31:0] PC_ID;
    logic        id_ready;

    instr_fetch #(.QDEPTH(QD)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC_IF      (PC_IF),
        .j_br       (j_br),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .valid_ID   (valid_ID),
        .instr_ID   (instr_ID),
        .PC_ID      (PC_ID),
        .id_ready   (id_ready)
    );

    always #5 clk = ~clk;

    // Reference model: decode queue, outstanding request, memory, PC register
    logic [63:0] mq[$];
    bit          ost_have = 1'b0;
    bit          ost_keep = 1'b0;
    logic [31:0] ost_pc   = 32'h0;
    bit          m_pend   = 1'b0;
    int          m_left   = 0;
    logic [31:0] m_data   = 32'h0;
    logic [31:0] pc       = 32'h0;
    int          lat_next = 1;
    bit          force_en = 1'b0;
    logic [31:0] force_word = 32'h0;

    int n_pass  = 0;
    int n_total = 0;
    int bad_seen = 0;

    logic        cap_req, cap_stall, cap_vld;
    logic [31:0] cap_pc, cap_ins, cap_addr;

    typedef struct {
        logic        idr;
        logic        gnt;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        req;
        logic        stl;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic idr, input logic gnt, input logic vld,
                                input logic [31:0] pcv, input logic [31:0] ins,
                                input logic req, input logic stl);
        vec_t v;
        v.idr = idr; v.gnt = gnt; v.vld = vld; v.pc = pcv;
        v.ins = ins; v.req = req; v.stl = stl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic step(input logic rst_i, input logic jbr_i, input logic gnt_i,
                        input logic idr_i, input logic [31:0] bta_i);
        bit          rv, psh, pp, req, acc, stl, vld;
        logic [31:0] epc, eins;
        int          occ;
        reset    = rst_i;
        j_br     = jbr_i;
        imem_gnt = gnt_i;
        id_ready = idr_i;
        PC_IF    = pc;
        rv = m_pend && (m_left == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? m_data : $urandom;

        vld  = (mq.size() != 0);
        epc  = vld ? mq[0][63:32] : 32'h0;
        eins = vld ? mq[0][31:0]  : 32'h0000_0013;
        psh  = ost_have && ost_keep && rv && !jbr_i;
        pp   = vld && idr_i && !jbr_i;
        occ  = mq.size() + int'(psh) - int'(pp);
        req  = !rst_i && !jbr_i && (!ost_have || (ost_keep && rv)) && (occ < QD);
        acc  = req && gnt_i;
        stl  = !acc;

        #2;
        cap_req = imem_req; cap_stall = stall; cap_vld = valid_ID;
        cap_pc = PC_ID; cap_ins = instr_ID; cap_addr = imem_addr;
        chk("imem_req",  32'(cap_req),   32'(req));
        chk("stall",     32'(cap_stall), 32'(stl));
        chk("valid_ID",  32'(cap_vld),   32'(vld));
        chk("PC_ID",     cap_pc,  epc);
        chk("instr_ID",  cap_ins, eins);
        chk("imem_addr", cap_addr, pc);
        if (cap_ins == 32'hDEAD || cap_ins == 32'hBEEF) bad_seen++;

        @(posedge clk);
        if (rst_i) begin
            mq.delete();
            ost_have = 1'b0; ost_keep = 1'b0; ost_pc = 32'h0;
            m_pend = 1'b0; pc = 32'h0;
        end else begin
            if (jbr_i) mq.delete();
            else begin
                if (pp)  void'(mq.pop_front());
                if (psh) mq.push_back({ost_pc, m_data});
            end
            if (rv) ost_have = 1'b0;
            else if (jbr_i) ost_keep = 1'b0;
            if (rv) m_pend = 1'b0;
            else if (m_pend) m_left--;
            if (acc) begin
                ost_have = 1'b1; ost_keep = 1'b1; ost_pc = pc;
                m_pend = 1'b1; m_left = lat_next - 1;
                m_data = force_en ? force_word : pc + 32'h100;
                force_en = 1'b0;
                lat_next = 1;
            end
            if (jbr_i) pc = bta_i;
            else if (acc) pc = pc + 32'd4;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; j_br = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
        PC_IF = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        //          idr   gnt   vld   PC_ID   instr_ID req   stall
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h00, 32'h013, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 32'h00, 32'h013, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b1, 32'h00, 32'h100, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b1, 32'h04, 32'h104, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 32'h108, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 32'h108, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 32'h108, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 32'h108, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 1'b1, 32'h0C, 32'h10C, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 32'h10, 32'h110, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 32'h14, 32'h114, 1'b1, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 32'h18, 32'h118, 1'b1, 1'b1);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 32'h00, 32'h013, 1'b1, 1'b1);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 32'h00, 32'h013, 1'b1, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 32'h00, 32'h013, 1'b1, 1'b1);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 32'h1C, 32'h11C, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        #1;

        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("rst_valid", 32'(cap_vld),   32'h0);
        chk("rst_instr", cap_ins,        32'h13);
        chk("rst_pc",    cap_pc,         32'h0);
        chk("rst_req",   32'(cap_req),   32'h0);
        chk("rst_stall", 32'(cap_stall), 32'h1);

        // Streaming, back-pressure and grant-hold vectors
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, tbl[i].gnt, tbl[i].idr, 32'h0);
            chk($sformatf("tbl%0d_req", i),   32'(cap_req),   32'(tbl[i].req));
            chk($sformatf("tbl%0d_stall", i), 32'(cap_stall), 32'(tbl[i].stl));
            chk($sformatf("tbl%0d_valid", i), 32'(cap_vld),   32'(tbl[i].vld));
            chk($sformatf("tbl%0d_pc", i),    cap_pc,         tbl[i].pc);
            chk($sformatf("tbl%0d_instr", i), cap_ins,        tbl[i].ins);
        end

        // Reset while a request is outstanding and the queue holds a word
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("wrst_valid_before", 32'(cap_vld), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("wrst_valid", 32'(cap_vld),   32'h0);
        chk("wrst_instr", cap_ins,        32'h13);
        chk("wrst_req",   32'(cap_req),   32'h0);
        chk("wrst_stall", 32'(cap_stall), 32'h1);

        // Branch while waiting; the late response must be dropped
        lat_next = 3; force_en = 1'b1; force_word = 32'hDEAD;
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("jw_q_empty", 32'(cap_vld), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("jw_drop_noissue", 32'(cap_req), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("jw_new_req",  32'(cap_req), 32'h1);
        chk("jw_new_addr", cap_addr,     32'h80);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("jw_pc",    cap_pc,  32'h80);
        chk("jw_instr", cap_ins, 32'h180);

        // Branch in the same cycle as the response
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        force_en = 1'b1; force_word = 32'hBEEF;
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        chk("jr_req", 32'(cap_req), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("jr_idle_req", 32'(cap_req), 32'h1);
        chk("jr_addr",     cap_addr,     32'h200);
        chk("jr_empty",    32'(cap_vld), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("jr_pc",    cap_pc,  32'h200);
        chk("jr_instr", cap_ins, 32'h300);
        chk("never_wrong_path", 32'(bad_seen), 32'h0);

        // Randomized traffic against the model
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            lat_next = int'($urandom_range(1, 3));
            step(($urandom % 200) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) != 0, 32'($urandom_range(0, 1023)) << 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
